// File: rtl/sec_mon_link_sched.sv
// Challenge/response scheduler for the security-monitor serial link.
// Issues LFSR challenges each period, checks the keyed echo, escalates repeated failures to an alarm.
module sec_mon_link_sched #(
    parameter int          TIMEOUT   = 1024,
    parameter int          MAX_FAIL  = 3,
    parameter logic [7:0]  KEY       = 8'hA5,
    parameter logic [7:0]  LFSR_SEED = 8'h5A
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        en_i,
    input  logic [15:0] period_i,
    input  logic        clr_alarm_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        alarm_o,
    output logic [3:0]  fail_cnt_o,
    output logic [15:0] ok_cnt_o,
    output logic        busy_o,
    output logic [2:0]  state_o
);
    localparam int         TW         = $clog2(TIMEOUT + 1);
    localparam logic [3:0] MAX_FAIL_L = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SEND  = 3'd2,
        ST_AWAIT = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pcnt_reg, pcnt_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [7:0]  lfsr_reg, lfsr_next;
    logic [7:0]  expected_reg, expected_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        alarm_reg, alarm_next;
    logic [3:0]  fail_cnt_reg, fail_cnt_next;
    logic [15:0] ok_cnt_reg, ok_cnt_next;

    logic [15:0] period_load;
    logic [3:0]  fail_inc;
    logic        handshake, pass_ev, fail_ev, alarm_trip;

    assign period_load = (period_i == 16'd0) ? 16'd1 : period_i;
    assign fail_inc    = (fail_cnt_reg == 4'hF) ? 4'hF : fail_cnt_reg + 4'd1;
    assign handshake   = (state_reg == ST_SEND) && tx_ready_i;
    // A response arriving on the expiry cycle is judged on its data; the timeout only fires without rx.
    assign pass_ev     = (state_reg == ST_AWAIT) && en_i && rx_valid_i && (rx_data_i == expected_reg);
    assign fail_ev     = (state_reg == ST_AWAIT) && en_i &&
                         ((rx_valid_i && (rx_data_i != expected_reg)) ||
                          (!rx_valid_i && (tcnt_reg == TW'(1))));
    assign alarm_trip  = fail_ev && !clr_alarm_i && (fail_inc >= MAX_FAIL_L);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg    <= ST_IDLE;
            pcnt_reg     <= 16'd0;
            tcnt_reg     <= '0;
            lfsr_reg     <= LFSR_SEED;
            expected_reg <= 8'd0;
            tx_data_reg  <= 8'd0;
            tx_valid_reg <= 1'b0;
            alarm_reg    <= 1'b0;
            fail_cnt_reg <= 4'd0;
            ok_cnt_reg   <= 16'd0;
        end else begin
            state_reg    <= state_next;
            pcnt_reg     <= pcnt_next;
            tcnt_reg     <= tcnt_next;
            lfsr_reg     <= lfsr_next;
            expected_reg <= expected_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            alarm_reg    <= alarm_next;
            fail_cnt_reg <= fail_cnt_next;
            ok_cnt_reg   <= ok_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (en_i) state_next = ST_WAIT;
            ST_WAIT: begin
                if (!en_i)                  state_next = ST_IDLE;
                else if (pcnt_reg == 16'd1) state_next = ST_SEND;
            end
            ST_SEND:  if (handshake) state_next = en_i ? ST_AWAIT : ST_IDLE;
            ST_AWAIT: begin
                if (!en_i)           state_next = ST_IDLE;
                else if (alarm_trip) state_next = ST_ALARM;
                else if (pass_ev || fail_ev) state_next = ST_WAIT;
            end
            ST_ALARM: if (clr_alarm_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pcnt_next     = pcnt_reg;
        tcnt_next     = tcnt_reg;
        lfsr_next     = lfsr_reg;
        expected_next = expected_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        alarm_next    = alarm_reg;
        fail_cnt_next = fail_cnt_reg;
        ok_cnt_next   = ok_cnt_reg;

        if (state_reg == ST_IDLE && en_i)
            pcnt_next = period_load;
        if (state_reg == ST_WAIT && en_i) begin
            if (pcnt_reg == 16'd1) begin
                tx_valid_next = 1'b1;
                tx_data_next  = lfsr_reg;
            end else begin
                pcnt_next = pcnt_reg - 16'd1;
            end
        end
        if (handshake) begin
            tx_valid_next = 1'b0;
            expected_next = lfsr_reg ^ KEY;
            // Galois step, shift right, feedback mask 0xB8 (x^8+x^6+x^5+x^4+1)
            lfsr_next     = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
            tcnt_next     = TW'(TIMEOUT);
        end
        if (state_reg == ST_AWAIT && tcnt_reg != '0)
            tcnt_next = tcnt_reg - TW'(1);
        if ((pass_ev || fail_ev) && !alarm_trip)
            pcnt_next = period_load;
        if (pass_ev && ok_cnt_reg != 16'hFFFF)
            ok_cnt_next = ok_cnt_reg + 16'd1;

        if (clr_alarm_i)  fail_cnt_next = 4'd0;
        else if (fail_ev) fail_cnt_next = fail_inc;
        else if (pass_ev) fail_cnt_next = 4'd0;

        if (alarm_trip) begin
            alarm_next    = 1'b1;
            tx_valid_next = 1'b0;
        end
        if (state_reg == ST_ALARM && clr_alarm_i)
            alarm_next = 1'b0;
    end

    assign tx_data_o  = tx_data_reg;
    assign tx_valid_o = tx_valid_reg;
    assign alarm_o    = alarm_reg;
    assign fail_cnt_o = fail_cnt_reg;
    assign ok_cnt_o   = ok_cnt_reg;
    assign state_o    = state_reg;
    assign busy_o     = (state_reg == ST_SEND) || (state_reg == ST_AWAIT);

endmodule

// File: tb/tb_sec_mon_link_sched.sv
// Directed bench for sec_mon_link_sched: challenge/response, backpressure, timeouts, alarm, abort and reset.
module tb_sec_mon_link_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] period;
    logic        clr_alarm;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        alarm;
    logic [3:0]  fail_cnt;
    logic [15:0] ok_cnt;
    logic        busy;
    logic [2:0]  state;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sec_mon_link_sched #(
        .TIMEOUT(16), .MAX_FAIL(3), .KEY(8'hA5), .LFSR_SEED(8'h5A)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .en_i(en), .period_i(period),
        .clr_alarm_i(clr_alarm), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .alarm_o(alarm), .fail_cnt_o(fail_cnt), .ok_cnt_o(ok_cnt),
        .busy_o(busy), .state_o(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        step(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; period = 16'd10; clr_alarm = 1'b0;
        tx_ready = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        step(3);
        check("rst_state", state, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_alarm", alarm, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_ok", ok_cnt, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step(1);

        // Nominal pass
        en = 1'b1;
        step(1);
        check("nom_wait_entry", state, 1);
        step(9);
        check("nom_no_valid_yet", tx_valid, 0);
        step(1);
        check("nom_send_state", state, 2);
        check("nom_tx_valid", tx_valid, 1);
        check("nom_tx_data", tx_data, 8'h5A);
        check("nom_busy_send", busy, 1);
        step(1);
        check("nom_await", state, 3);
        check("nom_valid_drop", tx_valid, 0);
        step(4);
        respond(8'hFF);
        check("nom_pass_state", state, 1);
        check("nom_ok", ok_cnt, 1);
        check("nom_fail", fail_cnt, 0);

        // Backpressure on the second challenge
        tx_ready = 1'b0;
        step(9);
        check("bp_still_wait", state, 1);
        step(1);
        check("bp_send", state, 2);
        check("bp_data", tx_data, 8'h2D);
        step(50);
        check("bp_hold_state", state, 2);
        check("bp_hold_valid", tx_valid, 1);
        check("bp_hold_data", tx_data, 8'h2D);
        tx_ready = 1'b1;
        step(1);
        check("bp_await", state, 3);

        // Corruption: expected 2D^A5=88, send 00
        step(2);
        respond(8'h00);
        check("corr_fail", fail_cnt, 1);
        check("corr_state", state, 1);
        check("corr_ok_held", ok_cnt, 1);

        // Correct response on the exact expiry cycle
        step(10);
        check("race_data", tx_data, 8'hAE);
        step(1);
        check("race_await", state, 3);
        step(15);
        check("race_not_expired", state, 3);
        respond(8'hAE ^ 8'hA5);
        check("race_pass_state", state, 1);
        check("race_fail_clr", fail_cnt, 0);
        check("race_ok", ok_cnt, 2);

        // Timeout escalation, no responses
        step(10);
        check("to1_data", tx_data, 8'h57);
        step(17);
        check("to1_state", state, 1);
        check("to1_fail", fail_cnt, 1);
        step(10);
        check("to2_data", tx_data, 8'h93);
        step(17);
        check("to2_fail", fail_cnt, 2);
        step(10);
        check("to3_data", tx_data, 8'hF1);
        step(17);
        check("alarm_state", state, 4);
        check("alarm_set", alarm, 1);
        check("alarm_fail", fail_cnt, 3);
        check("alarm_tx_valid", tx_valid, 0);
        step(5);
        check("alarm_sticky", state, 4);
        respond(8'hF1 ^ 8'hA5);
        check("alarm_rx_ignored", ok_cnt, 2);
        clr_alarm = 1'b1;
        step(1);
        clr_alarm = 1'b0;
        check("clr_state", state, 0);
        check("clr_alarm", alarm, 0);
        check("clr_fail", fail_cnt, 0);
        check("clr_ok_held", ok_cnt, 2);

        // period_i=0 acts as 1; wrong response to leave fail_cnt=1
        period = 16'd0;
        step(1);
        check("p0_wait", state, 1);
        step(1);
        check("p0_send", state, 2);
        check("p0_data", tx_data, 8'hC0);
        step(1);
        respond(8'h12);
        check("p0_fail", fail_cnt, 1);

        // Abort in AWAIT keeps fail_cnt
        step(1);
        check("ab_send", state, 2);
        check("ab_data", tx_data, 8'h60);
        step(1);
        check("ab_await", state, 3);
        step(3);
        en = 1'b0;
        step(1);
        check("ab_idle", state, 0);
        check("ab_fail_held", fail_cnt, 1);
        respond(8'h60 ^ 8'hA5);
        check("idle_rx_ignored", ok_cnt, 2);

        // clr outside ALARM clears fail_cnt only
        clr_alarm = 1'b1;
        step(1);
        clr_alarm = 1'b0;
        check("clr_idle_fail", fail_cnt, 0);
        check("clr_idle_state", state, 0);

        // Asynchronous reset mid-SEND
        en = 1'b1; period = 16'd4; tx_ready = 1'b0;
        step(5);
        check("rs_send", state, 2);
        check("rs_data", tx_data, 8'h30);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", tx_valid, 0);
        check("rs_async_state", state, 0);
        check("rs_async_ok", ok_cnt, 0);
        step(1);
        rst_n = 1'b1; tx_ready = 1'b1; period = 16'd2;
        step(3);
        check("rs_reseed_send", state, 2);
        check("rs_reseed_data", tx_data, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
